// File: rtl/md5_pad_pkg.sv
// Shared MD5 padder constants, block geometry and FSM encodings.
// Included by md5_pad and md5_len_field through import md5_pad_pkg::*.
package md5_pad_pkg;

    localparam int MD5_BLK_W    = 512;
    localparam int MD5_LEN_W    = 64;
    localparam int MD5_LEN_LANE = 56;
    localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/md5_len_field.sv
// Combinational: 6-bit message byte count -> 64-bit bit-length field, laid out
// so that mesg lane 56 (bits [63:56]) carries the least-significant byte.
module md5_len_field
    import md5_pad_pkg::*;
(
    input  logic [5:0]           len_bytes_i,
    output logic [MD5_LEN_W-1:0] len_field_o
);

    logic [MD5_LEN_W-1:0] bit_len;

    always_comb begin
        bit_len     = {55'd0, len_bytes_i, 3'd0};
        len_field_o = '0;
        for (int i = 0; i < 8; i++) begin
            len_field_o[MD5_LEN_W-1-8*i -: 8] = bit_len[8*i +: 8];
        end
    end

endmodule

// File: rtl/md5_pad.sv
// md5_pad: collects a 1..MAX_LEN byte message and emits one MD5-padded 512-bit block.
// Optional macro MD5_PAD_STATS_EN adds saturating blk_count/drop_count outputs.
module md5_pad
    import md5_pad_pkg::*;
#(
    parameter int MAX_LEN = 55
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    input  logic                 byte_last,
    output logic                 byte_ready,
    output logic [MD5_BLK_W-1:0] mesg,
    output logic                 valid_out,
`ifdef MD5_PAD_STATS_EN
    output logic                 err_out,
    output logic [15:0]          blk_count,
    output logic [15:0]          drop_count
`else
    output logic                 err_out
`endif
);

    localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

    state_t               state_q, state_d;
    logic [5:0]           count_q, count_d;
    logic [MD5_BLK_W-1:0] buf_q, buf_d;
    logic [MD5_BLK_W-1:0] mesg_q, mesg_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 room;
    logic [MD5_LEN_W-1:0] len_field;
    logic [MD5_BLK_W-1:0] buf_wr;
    logic [MD5_BLK_W-1:0] blk_w;

    assign byte_ready = en && (state_q != ST_EMIT);
    assign accept     = byte_valid && byte_ready;
    assign room       = (count_q < MAX_CNT);

    md5_len_field u_len_field (
        .len_bytes_i (count_q + 6'd1),
        .len_field_o (len_field)
    );

    // Buffer lanes above count are always zero, so only the data, pad and length lanes need patching.
    always_comb begin
        buf_wr = buf_q;
        blk_w  = buf_q;
        for (int i = 0; i < MD5_LEN_LANE; i++) begin
            if (i == int'(count_q)) begin
                buf_wr[MD5_BLK_W-1-8*i -: 8] = byte_in;
                blk_w[MD5_BLK_W-1-8*i -: 8]  = byte_in;
            end
            if (i == int'(count_q) + 1) begin
                blk_w[MD5_BLK_W-1-8*i -: 8] = MD5_PAD_BYTE;
            end
        end
        blk_w[MD5_LEN_W-1:0] = len_field;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        buf_d   = buf_q;
        mesg_d  = mesg_q;
        valid_d = valid_q;
        err_d   = err_q;
        // With en low every register, including the output pulses, simply holds.
        if (en) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (room && byte_last) begin
                            mesg_d  = blk_w;
                            valid_d = 1'b1;
                            state_d = ST_EMIT;
                            count_d = '0;
                            buf_d   = '0;
                        end else if (room) begin
                            buf_d   = buf_wr;
                            count_d = count_q + 6'd1;
                        end else if (byte_last) begin
                            err_d   = 1'b1;
                            count_d = '0;
                            buf_d   = '0;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_EMIT: begin
                    state_d = ST_ACCUM;
                end
                ST_DRAIN: begin
                    if (accept && byte_last) begin
                        err_d   = 1'b1;
                        count_d = '0;
                        buf_d   = '0;
                        state_d = ST_ACCUM;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                    count_d = '0;
                    buf_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            count_q <= '0;
            buf_q   <= '0;
            mesg_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            mesg_q  <= mesg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign mesg      = mesg_q;
    assign valid_out = valid_q;
    assign err_out   = err_q;

`ifdef MD5_PAD_STATS_EN
    logic [15:0] blk_cnt_q;
    logic [15:0] drop_cnt_q;

    // Count pulse events, not cycles: a pulse stretched by en low is still one block.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (en) begin
            if (valid_d && (blk_cnt_q != 16'hFFFF)) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
            if (err_d && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign blk_count  = blk_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_md5_pad.sv
// Self-checking bench for md5_pad: vector table plus hand-written corner sequences,
// with a scoreboard queue consumed by an output monitor.
module tb_md5_pad;

    logic         clk;
    logic         reset;
    logic         en;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_last;
    logic         byte_ready;
    logic [511:0] mesg;
    logic         valid_out;
    logic         err_out;
`ifdef MD5_PAD_STATS_EN
    logic [15:0]  blk_count;
    logic [15:0]  drop_count;
`endif

    md5_pad #(.MAX_LEN(55)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .mesg       (mesg),
        .valid_out  (valid_out),
`ifdef MD5_PAD_STATS_EN
        .err_out    (err_out),
        .blk_count  (blk_count),
        .drop_count (drop_count)
`else
        .err_out    (err_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           len;
        logic [7:0]   d[64];
        bit           exp_err;
        logic [511:0] exp_m;
    } vec_t;

    typedef struct packed {
        logic         is_err;
        logic [511:0] mesg;
    } sb_t;

    localparam logic [511:0] HELLO_BLK =
        {96'h48656c6c_6f20576f_726c6480, 352'h0, 64'h58000000_00000000};

    sb_t     sb[$];
    int      vtimes[$];
    int      tests_run    = 0;
    int      tests_failed = 0;
    int      cyc          = 0;
    int      n_blk        = 0;
    int      n_drop       = 0;
    vec_t    vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference padding built straight from the MD5 message layout.
    function automatic logic [511:0] pad_ref(input logic [7:0] d[64], input int len);
        logic [7:0]   b[64];
        logic [63:0]  bits;
        logic [511:0] r;
        for (int i = 0; i < 64; i++) b[i] = (i < len) ? d[i] : 8'h00;
        b[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) b[56+k] = bits[8*k +: 8];
        for (int i = 0; i < 64; i++) r[511-8*i -: 8] = b[i];
        return r;
    endfunction

    function automatic vec_t mk_vec(input string s, input int rep, input bit err);
        vec_t v;
        for (int i = 0; i < 64; i++) v.d[i] = 8'h00;
        if (s.len() > 0) begin
            v.len = s.len();
            for (int i = 0; i < v.len; i++) v.d[i] = s[i];
        end else begin
            v.len = rep;
            for (int i = 0; i < 64 && i < rep; i++) v.d[i] = 8'h41;
        end
        v.exp_err = err;
        v.exp_m   = err ? 512'h0 : pad_ref(v.d, (v.len > 55) ? 55 : v.len);
        return v;
    endfunction

    // Monitor: each rising edge of valid_out/err_out consumes one scoreboard entry.
    initial begin
        logic pv, pe;
        sb_t  e;
        pv = 1'b0;
        pe = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_out && !pv) begin
                vtimes.push_back(cyc);
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("sb_kind_valid", e.is_err, 0);
                    chk("sb_mesg", mesg, e.mesg);
                end
            end
            if (err_out && !pe) begin
                if (sb.size() == 0) chk("unexpected_err", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("sb_kind_err", e.is_err, 1);
                end
            end
            pv = valid_out;
            pe = err_out;
        end
    end

    task automatic wait_accept(inout int waits);
        bit rdy;
        int guard;
        rdy   = 1'b0;
        guard = 0;
        while (!rdy && guard < 100) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (!rdy) begin
                waits++;
                guard++;
            end
        end
        if (!rdy) chk("ready_timeout", 0, 1);
    endtask

    task automatic stall(input int n, input bit in_emit);
        en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("stall_ready_low", byte_ready, 0);
            if (in_emit) chk("stall_valid_held", valid_out, 1);
            @(posedge clk);
            #1;
        end
        en = 1'b1;
    endtask

    task automatic send_msg(input logic [7:0] d[64], input int len, input int stall_at,
                            input bit stall_emit, input bit exp_err, input logic [511:0] exp_m,
                            input bit hold, output int waits);
        sb_t e;
        e.is_err = exp_err;
        e.mesg   = exp_m;
        sb.push_back(e);
        if (exp_err) n_drop++; else n_blk++;
        waits = 0;
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) stall(5, 1'b0);
            byte_in    = d[i];
            byte_valid = 1'b1;
            byte_last  = (i == len - 1);
            wait_accept(waits);
        end
        if (exp_err) chk("latency_err", err_out, 1);
        else         chk("latency_valid", valid_out, 1);
        if (!hold) begin
            byte_valid = 1'b0;
            byte_last  = 1'b0;
        end
        if (stall_emit) stall(5, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset  = 1'b0;
        n_blk  = 0;
        n_drop = 0;
        @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_mesg", mesg, 0);
        chk("rst_ready", byte_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           w, w2;
        logic [511:0] last_m;
        vec_t         fox;

        vecs[0] = mk_vec("Hello World", 0, 1'b0);
        vecs[0].exp_m = HELLO_BLK;
        vecs[1] = mk_vec("The quick brown fox jumps over the lazy dog", 0, 1'b0);
        vecs[2] = mk_vec("", 55, 1'b0);
        vecs[3] = mk_vec("", 56, 1'b1);
        vecs[4] = mk_vec("a", 0, 1'b0);
        vecs[5] = mk_vec("", 60, 1'b1);

        en = 1'b1;
        reset = 1'b1;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        idle(3);
        do_reset();

        last_m = 512'h0;
        for (int k = 0; k < 6; k++) begin
            send_msg(vecs[k].d, vecs[k].len, -1, 1'b0, vecs[k].exp_err, vecs[k].exp_m, 1'b0, w);
            if (!vecs[k].exp_err) last_m = vecs[k].exp_m;
            if (k == 1) begin
                chk("fox_tail", mesg[63:0], 64'h58010000_00000000);
                chk("fox_pad_lane43", mesg[511-8*43 -: 8], 8'h80);
            end
            if (k == 2) begin
                chk("a55_tail", mesg[63:0], 64'hB8010000_00000000);
                chk("a55_pad_lane55", mesg[71:64], 8'h80);
            end
            idle(4);
            chk("sb_drained", sb.size(), 0);
            chk("mesg_hold", mesg, last_m);
        end

        // Back-to-back messages with byte_valid held high across the boundary.
        send_msg(vecs[0].d, 11, -1, 1'b0, 1'b0, HELLO_BLK, 1'b1, w);
        send_msg(vecs[0].d, 11, -1, 1'b0, 1'b0, HELLO_BLK, 1'b0, w2);
        chk("b2b_ready_gap", w2, 1);
        idle(3);
        chk("b2b_spacing", vtimes[vtimes.size()-1] - vtimes[vtimes.size()-2], 12);
        chk("b2b_drained", sb.size(), 0);

        // en low mid-message and across the emit cycle.
        send_msg(vecs[0].d, 11, 5, 1'b1, 1'b0, HELLO_BLK, 1'b0, w);
        idle(1);
        chk("stall_pulse_end", valid_out, 0);
        idle(3);
        chk("stall_drained", sb.size(), 0);

`ifdef MD5_PAD_STATS_EN
        chk("stat_blk", blk_count, 16'(n_blk));
        chk("stat_drop", drop_count, 16'(n_drop));
`endif

        // Reset in the middle of a message discards it silently.
        fox = vecs[1];
        w = 0;
        for (int i = 0; i < 6; i++) begin
            byte_in    = fox.d[i];
            byte_valid = 1'b1;
            byte_last  = 1'b0;
            wait_accept(w);
        end
        byte_valid = 1'b0;
        do_reset();
        send_msg(vecs[0].d, 11, -1, 1'b0, 1'b0, HELLO_BLK, 1'b0, w);
        idle(4);
        chk("rst_mid_drained", sb.size(), 0);
        chk("rst_mid_mesg", mesg, HELLO_BLK);

`ifdef MD5_PAD_STATS_EN
        chk("stat_blk_after_rst", blk_count, 16'(n_blk));
        chk("stat_drop_after_rst", drop_count, 16'(n_drop));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
